bcd_xs3_serial_conv: RTL and testbench

Parametrised, bidirectional multi-digit BCD / Excess-3 code converter. It accepts a packed word of `DIGITS` nibbles over a valid/ready handshake and converts one digit per clock, least-significant digit first, in either direction. It flags every digit that is invalid in the source code. It is the sequential, multi-digit successor to the single-digit combinational BCD-to-Excess-3 converter and feeds the display and arithmetic datapaths.

---
 rtl/bcd_pkg.sv | 18 +
 rtl/xs3_digit.sv | 29 ++
 rtl/bcd_xs3_serial_conv.sv | 114 +++++++++++
 tb/tb_bcd_xs3_serial_conv.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial BCD / Excess-3 converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_e;

    localparam logic [3:0] XS3_OFFSET = 4'd3;
    localparam logic [3:0] BCD_MAX    = 4'd9;
    localparam logic [3:0] XS3_MIN    = 4'd3;
    localparam logic [3:0] XS3_MAX    = 4'd12;

    localparam logic MODE_BCD2XS3 = 1'b0;
    localparam logic MODE_XS32BCD = 1'b1;

endpackage

// File: rtl/xs3_digit.sv
// Single-digit BCD <-> Excess-3 conversion; invalid source digits give 0 with the flag set.
module xs3_digit
    import bcd_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       mode,
    output logic [3:0] result,
    output logic       invalid
);

    always_comb begin
        result  = 4'd0;
        invalid = 1'b0;
        if (mode == MODE_BCD2XS3) begin
            if (digit <= BCD_MAX) begin
                result = digit + XS3_OFFSET;
            end else begin
                invalid = 1'b1;
            end
        end else begin
            if ((digit >= XS3_MIN) && (digit <= XS3_MAX)) begin
                result = digit - XS3_OFFSET;
            end else begin
                invalid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bcd_xs3_serial_conv.sv
// Multi-digit BCD / Excess-3 converter, one digit per clock, LSD first, valid/ready on both sides.
module bcd_xs3_serial_conv
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  mode,
    input  logic [4*DIGITS-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_data,
    output logic [DIGITS-1:0]     err_mask,
    output logic                  out_err
);

    localparam int unsigned CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [4*DIGITS-1:0]   word_q, word_d;
    logic                  mode_q, mode_d;
    logic [4*DIGITS-1:0]   out_data_q, out_data_d;
    logic [DIGITS-1:0]     err_q, err_d;

    logic [3:0] cur_digit;
    logic [3:0] cur_result;
    logic       cur_invalid;

    // Loop mux avoids out-of-range part-selects when DIGITS is not a power of two.
    always_comb begin
        cur_digit = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (cnt_q == CW'(i)) begin
                cur_digit = word_q[4*i +: 4];
            end
        end
    end

    xs3_digit u_digit (
        .digit   (cur_digit),
        .mode    (mode_q),
        .result  (cur_result),
        .invalid (cur_invalid)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        word_d     = word_q;
        mode_d     = mode_q;
        out_data_d = out_data_q;
        err_d      = err_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    word_d     = in_data;
                    mode_d     = mode;
                    cnt_d      = '0;
                    out_data_d = '0;
                    err_d      = '0;
                    state_d    = CONV;
                end
            end
            CONV: begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (cnt_q == CW'(i)) begin
                        out_data_d[4*i +: 4] = cur_result;
                        err_d[i]             = cur_invalid;
                    end
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            word_q     <= '0;
            mode_q     <= MODE_BCD2XS3;
            out_data_q <= '0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            word_q     <= word_d;
            mode_q     <= mode_d;
            out_data_q <= out_data_d;
            err_q      <= err_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = out_data_q;
    assign err_mask  = err_q;
    assign out_err   = |err_q;

endmodule

// File: tb/tb_bcd_xs3_serial_conv.sv
// Directed bench for bcd_xs3_serial_conv with a 4-digit and a 1-digit instance.
module tb_bcd_xs3_serial_conv;

    logic        clk;
    logic        rst;

    logic        in_valid, in_ready, mode, out_valid, out_ready, out_err;
    logic [15:0] in_data, out_data;
    logic [3:0]  err_mask;

    logic        in_valid1, in_ready1, mode1, out_valid1, out_ready1, out_err1;
    logic [3:0]  in_data1, out_data1;
    logic [0:0]  err_mask1;

    int n_cmp;
    int n_err;

    bcd_xs3_serial_conv #(.DIGITS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .err_mask  (err_mask),
        .out_err   (out_err)
    );

    bcd_xs3_serial_conv #(.DIGITS(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .mode      (mode1),
        .in_data   (in_data1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .out_data  (out_data1),
        .err_mask  (err_mask1),
        .out_err   (out_err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus only: accepts a word on the 4-digit DUT and returns cycles until out_valid.
    task automatic send(input logic m, input logic [15:0] d, output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            n_cmp++; n_err++;
            $display("FAIL send_wait_in_ready: in_ready=%b required 1", in_ready);
        end
        in_valid = 1'b1; mode = m; in_data = d;
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = 16'hFFFF; mode = ~m;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            if (lat < 0) begin
                @(posedge clk); #1;
                if (out_valid) lat = i;
            end
        end
        if (lat < 0) begin
            n_cmp++; n_err++;
            $display("FAIL send_wait_out_valid: timed out, out_valid=%b required 1", out_valid);
        end
    endtask

    task automatic finish_xfer();
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        n_cmp++; if (in_ready !== 1'b1)   begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0)  begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_data !== 16'h0)  begin n_err++; $display("FAIL reset_out_data: got %h want 0000", out_data); end
        n_cmp++; if (err_mask !== 4'h0)   begin n_err++; $display("FAIL reset_err_mask: got %b want 0000", err_mask); end
        n_cmp++; if (out_err !== 1'b0)    begin n_err++; $display("FAIL reset_out_err: got %b want 0", out_err); end
        n_cmp++; if (in_ready1 !== 1'b1)  begin n_err++; $display("FAIL reset_in_ready_d1: got %b want 1", in_ready1); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_bcd2xs3();
        int lat;
        send(1'b0, 16'h1234, lat);
        n_cmp++; if (lat != 4)              begin n_err++; $display("FAIL b2x_latency: got %0d want 4", lat); end
        n_cmp++; if (out_data !== 16'h4567) begin n_err++; $display("FAIL b2x_data: got %h want 4567", out_data); end
        n_cmp++; if (err_mask !== 4'b0000)  begin n_err++; $display("FAIL b2x_err_mask: got %b want 0000", err_mask); end
        n_cmp++; if (out_err !== 1'b0)      begin n_err++; $display("FAIL b2x_out_err: got %b want 0", out_err); end
        finish_xfer();
        n_cmp++; if (in_ready !== 1'b1)     begin n_err++; $display("FAIL b2x_in_ready_after: got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0)    begin n_err++; $display("FAIL b2x_out_valid_after: got %b want 0", out_valid); end
    endtask

    task automatic test_xs32bcd();
        int lat;
        send(1'b1, 16'hCCC3, lat);
        n_cmp++; if (out_data !== 16'h9990) begin n_err++; $display("FAIL x2b_data: got %h want 9990", out_data); end
        n_cmp++; if (err_mask !== 4'b0000)  begin n_err++; $display("FAIL x2b_err_mask: got %b want 0000", err_mask); end
        finish_xfer();
    endtask

    task automatic test_invalid_bcd();
        int lat;
        // Digit 1 (bits 7:4) holds A.
        send(1'b0, 16'h12A9, lat);
        n_cmp++; if (out_data !== 16'h450C) begin n_err++; $display("FAIL inv_bcd_data: got %h want 450C", out_data); end
        n_cmp++; if (err_mask !== 4'b0010)  begin n_err++; $display("FAIL inv_bcd_err_mask: got %b want 0010", err_mask); end
        n_cmp++; if (out_err !== 1'b1)      begin n_err++; $display("FAIL inv_bcd_out_err: got %b want 1", out_err); end
        finish_xfer();
    endtask

    task automatic test_invalid_xs3();
        int lat;
        send(1'b1, 16'hF203, lat);
        n_cmp++; if (out_data !== 16'h0000) begin n_err++; $display("FAIL inv_xs3_data: got %h want 0000", out_data); end
        n_cmp++; if (err_mask !== 4'b1110)  begin n_err++; $display("FAIL inv_xs3_err_mask: got %b want 1110", err_mask); end
        n_cmp++; if (out_err !== 1'b1)      begin n_err++; $display("FAIL inv_xs3_out_err: got %b want 1", out_err); end
        finish_xfer();
    endtask

    task automatic test_backpressure();
        int lat;
        out_ready = 1'b0;
        send(1'b0, 16'h1234, lat);
        for (int c = 0; c < 5; c++) begin
            in_valid = (c == 1 || c == 2);
            in_data  = 16'h5555;
            mode     = 1'b0;
            n_cmp++; if (out_valid !== 1'b1)    begin n_err++; $display("FAIL bp_out_valid c%0d: got %b want 1", c, out_valid); end
            n_cmp++; if (out_data !== 16'h4567) begin n_err++; $display("FAIL bp_out_data c%0d: got %h want 4567", c, out_data); end
            n_cmp++; if (err_mask !== 4'b0000)  begin n_err++; $display("FAIL bp_err_mask c%0d: got %b want 0000", c, err_mask); end
            n_cmp++; if (in_ready !== 1'b0)     begin n_err++; $display("FAIL bp_in_ready c%0d: got %b want 0", c, in_ready); end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        finish_xfer();
        n_cmp++; if (in_ready !== 1'b1)  begin n_err++; $display("FAIL bp_in_ready_release: got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_out_valid_release: got %b want 0", out_valid); end
        send(1'b0, 16'h0000, lat);
        n_cmp++; if (out_data !== 16'h3333) begin n_err++; $display("FAIL bp_next_word: got %h want 3333", out_data); end
        finish_xfer();
    endtask

    task automatic test_reset_mid_conv();
        int lat;
        in_valid = 1'b1; mode = 1'b0; in_data = 16'h1234;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        #2;
        n_cmp++; if (in_ready !== 1'b1)   begin n_err++; $display("FAIL rmid_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0)  begin n_err++; $display("FAIL rmid_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_data !== 16'h0)  begin n_err++; $display("FAIL rmid_out_data: got %h want 0000", out_data); end
        n_cmp++; if (err_mask !== 4'h0)   begin n_err++; $display("FAIL rmid_err_mask: got %b want 0000", err_mask); end
        #1;
        rst = 1'b0;
        // No stray out_valid may follow the aborted word.
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_no_pulse c%0d: got %b want 0", c, out_valid); end
        end
        send(1'b0, 16'h0999, lat);
        n_cmp++; if (out_data !== 16'h3CCC) begin n_err++; $display("FAIL rmid_next_data: got %h want 3CCC", out_data); end
        n_cmp++; if (err_mask !== 4'b0000)  begin n_err++; $display("FAIL rmid_next_err: got %b want 0000", err_mask); end
        finish_xfer();
    endtask

    task automatic test_digits1();
        int lat;
        logic [3:0] vin  [2] = '{4'h7, 4'hB};
        logic       vm   [2] = '{1'b0, 1'b1};
        logic [3:0] vout [2] = '{4'hA, 4'h8};
        for (int v = 0; v < 2; v++) begin
            in_valid1 = 1'b1; mode1 = vm[v]; in_data1 = vin[v];
            @(posedge clk); #1;
            in_valid1 = 1'b0; in_data1 = 4'hF;
            lat = -1;
            for (int i = 1; i <= 10; i++) begin
                if (lat < 0) begin
                    if (i > 1) begin @(posedge clk); #1; end
                    if (out_valid1) lat = i - 1;
                end
            end
            // lat counts edges after the accept edge; expect exactly one.
            if (lat < 0) begin
                @(posedge clk); #1;
                if (out_valid1) lat = 10;
            end
            n_cmp++; if (lat != 1 && !(lat == 0 && out_valid1))
                begin n_err++; $display("FAIL d1_latency v%0d: got %0d want 1", v, lat); end
            n_cmp++; if (out_data1 !== vout[v]) begin n_err++; $display("FAIL d1_data v%0d: got %h want %h", v, out_data1, vout[v]); end
            n_cmp++; if (out_err1 !== 1'b0)     begin n_err++; $display("FAIL d1_out_err v%0d: got %b want 0", v, out_err1); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        in_valid = 1'b0; mode = 1'b0; in_data = 16'h0; out_ready = 1'b1;
        in_valid1 = 1'b0; mode1 = 1'b0; in_data1 = 4'h0; out_ready1 = 1'b1;
        test_reset();
        test_bcd2xs3();
        test_xs32bcd();
        test_invalid_bcd();
        test_invalid_xs3();
        test_backpressure();
        test_reset_mid_conv();
        test_digits1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
